// File: rtl/fpu_cpu_interface.sv
// CPU-side register window for the FPU core: byte-wise operand/opcode assembly,
// start/ack handshake towards the core, status/IRQ reporting and a hang watchdog.
module fpu_cpu_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned NUM_OPS        = 13
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        irq,
    output logic [31:0] a_operand,
    output logic [31:0] b_operand,
    output logic [3:0]  operation,
    output logic        core_start,
    output logic        core_ack,
    input  logic        core_done,
    input  logic [31:0] core_result
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WD_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_ACK   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic             wr_lvl_q;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             irq_en_q, irq_en_d;
    logic [31:0]      result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             core_start_q, core_start_d;
    logic             core_ack_q, core_ack_d;
    logic             irq_q, irq_d;

    logic wr_lvl, wr_ev, wr_ctl, wr_ok, busy_hit, cmd_wr;
    logic op_legal, start_req, start_bad, clr_req, wd_hit;
    logic unused_din;

    // Bus write decode: one event per cs&wr assertion, regardless of strobe length
    assign wr_lvl    = cs & wr;
    assign wr_ev     = wr_lvl & ~wr_lvl_q;
    assign wr_ctl    = wr_ev && (addr <= 4'd9);
    assign busy_hit  = wr_ctl && busy_q;
    assign wr_ok     = wr_ctl && !busy_q;
    assign cmd_wr    = wr_ok && (addr == 4'd9);
    assign op_legal  = 32'(op_q) < NUM_OPS;
    assign start_req = cmd_wr && din[0] && op_legal;
    assign start_bad = cmd_wr && din[0] && !op_legal;
    assign clr_req   = cmd_wr && din[1];
    assign wd_hit    = WD_EN && (state_q == S_START) && (cnt_q == CNT_W'(WD_LAST));

    assign unused_din = ^din[6:4];

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a core answer beats a simultaneous watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_req) state_d = S_START;
            end
            S_START: begin
                if (core_done)   state_d = S_ACK;
                else if (wd_hit) state_d = S_IDLE;
            end
            S_ACK: begin
                if (!core_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs, registered from the next state
    always_comb begin
        core_start_d = 1'b0;
        core_ack_d   = 1'b0;
        case (state_d)
            S_START: core_start_d = 1'b1;
            S_ACK:   core_ack_d   = 1'b1;
            default: ;
        endcase
    end

    // Register file, status flags, result capture and watchdog counter
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        irq_en_d  = irq_en_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        if (wr_ok && (addr[3:2] == 2'b00)) a_d[{addr[1:0], 3'b000} +: 8] = din;
        if (wr_ok && (addr[3:2] == 2'b01)) b_d[{addr[1:0], 3'b000} +: 8] = din;
        if (wr_ok && (addr == 4'd8)) begin
            op_d     = din[3:0];
            irq_en_d = din[7];
        end

        if (clr_req) begin
            done_d    = 1'b0;
            error_d   = 1'b0;
            timeout_d = 1'b0;
        end
        if (start_req) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end
        if (start_bad || busy_hit) error_d = 1'b1;

        if (state_q == S_START && core_done) result_d = core_result;
        if (state_q == S_START && !core_done && wd_hit) begin
            busy_d    = 1'b0;
            timeout_d = 1'b1;
        end
        if (state_q == S_ACK && !core_done) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (state_q != S_START && state_d == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_START && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_lvl_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            irq_en_q     <= 1'b0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
            core_start_q <= 1'b0;
            core_ack_q   <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            wr_lvl_q     <= wr_lvl;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            irq_en_q     <= irq_en_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            core_start_q <= core_start_d;
            core_ack_q   <= core_ack_d;
            irq_q        <= irq_d;
        end
    end

    // Read mux: combinational, side-effect free
    always_comb begin
        dout = 8'h00;
        if (cs && rd) begin
            case (addr[3:2])
                2'b00: dout = a_q[{addr[1:0], 3'b000} +: 8];
                2'b01: dout = b_q[{addr[1:0], 3'b000} +: 8];
                2'b10: begin
                    case (addr[1:0])
                        2'd0:    dout = {irq_en_q, 3'b000, op_q};
                        2'd2:    dout = {4'b0000, timeout_q, error_q, done_q, busy_q};
                        default: dout = 8'h00;
                    endcase
                end
                default: dout = result_q[{addr[1:0], 3'b000} +: 8];
            endcase
        end
    end

    assign a_operand  = a_q;
    assign b_operand  = b_q;
    assign operation  = op_q;
    assign core_start = core_start_q;
    assign core_ack   = core_ack_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_fpu_cpu_interface.sv
// Directed bench for fpu_cpu_interface with a behavioural FPU core that answers
// after a programmable number of core_start cycles (0 = never answers).
module tb_fpu_cpu_interface;

    localparam int unsigned TO = 24;

    logic        clk;
    logic        arst;
    logic        cs, wr, rd;
    logic [3:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        irq;
    logic [31:0] a_operand, b_operand;
    logic [3:0]  operation;
    logic        core_start, core_ack;
    logic        core_done;
    logic [31:0] core_result;

    int          n_checks;
    int          n_errors;
    int          start_rises;
    int          core_lat;
    logic [31:0] core_val;
    int          st_cnt;

    fpu_cpu_interface #(.TIMEOUT_CYCLES(TO), .NUM_OPS(13)) dut (
        .clk         (clk),
        .arst        (arst),
        .cs          (cs),
        .wr          (wr),
        .rd          (rd),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .irq         (irq),
        .a_operand   (a_operand),
        .b_operand   (b_operand),
        .operation   (operation),
        .core_start  (core_start),
        .core_ack    (core_ack),
        .core_done   (core_done),
        .core_result (core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial start_rises = 0;
    always @(posedge core_start) start_rises++;

    // Behavioural core: raise done after core_lat start cycles, drop it once acked
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        st_cnt      = 0;
        forever begin
            @(negedge clk);
            if (core_done) begin
                if (core_ack) core_done = 1'b0;
            end else if (core_start) begin
                st_cnt++;
                if (core_lat != 0 && st_cnt == core_lat) begin
                    core_done   = 1'b1;
                    core_result = core_val;
                end
            end else begin
                st_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = dout;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd_reg(a, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        for (int i = 0; i < 4; i++) wr_reg(4'(i), a[8*i +: 8]);
        for (int i = 0; i < 4; i++) wr_reg(4'(4 + i), b[8*i +: 8]);
        wr_reg(4'd8, op);
    endtask

    // Wait until the handshake returns to idle, counting cycles with core_start high
    task automatic run_op(output int hi);
        bit ok;
        ok = 1'b0;
        hi = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (core_start) hi++;
            if (!core_start && !core_ack) ok = 1'b1;
            else @(negedge clk);
        end
        check("op_finished", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int hi;
        int r0;
        n_checks = 0;
        n_errors = 0;
        arst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
        core_lat = 20; core_val = 32'h4040_0000;

        repeat (2) @(negedge clk);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        arst = 1'b0;
        check_reg("rst_status", 4'd10, 8'h00);
        check("dout_no_rd", 32'(dout), 32'd0);

        // Basic add: 1.0 + 2.0 = 3.0
        load_ops(32'h3F80_0000, 32'h4000_0000, 8'h00);
        check("a_operand", a_operand, 32'h3F80_0000);
        check("b_operand", b_operand, 32'h4000_0000);
        wr_reg(4'd9, 8'h01);
        check("start_latency", 32'(core_start), 32'd1);
        run_op(hi);
        check("start_cycles", 32'(hi), 32'd20);
        check_reg("status_done", 4'd10, 8'h02);
        check_reg("res_b0", 4'd12, 8'h00);
        check_reg("res_b1", 4'd13, 8'h00);
        check_reg("res_b2", 4'd14, 8'h40);
        check_reg("res_b3", 4'd15, 8'h40);
        check("irq_disabled", 32'(irq), 32'd0);

        // Illegal opcode
        wr_reg(4'd9, 8'h02);
        check_reg("status_clr", 4'd10, 8'h00);
        wr_reg(4'd8, 8'h0E);
        r0 = start_rises;
        wr_reg(4'd9, 8'h01);
        repeat (4) @(negedge clk);
        check("bad_op_no_start", 32'(start_rises - r0), 32'd0);
        check_reg("status_bad_op", 4'd10, 8'h04);
        wr_reg(4'd9, 8'h02);
        check_reg("status_clr2", 4'd10, 8'h00);

        // Watchdog: core never answers
        wr_reg(4'd8, 8'h00);
        core_lat = 0;
        wr_reg(4'd9, 8'h01);
        run_op(hi);
        check("timeout_cycles", 32'(hi), 32'(TO));
        check_reg("status_timeout", 4'd10, 8'h08);
        wr_reg(4'd9, 8'h02);

        // core_done on the very cycle the watchdog expires
        core_lat = TO; core_val = 32'hDEAD_BEEF;
        wr_reg(4'd9, 8'h01);
        run_op(hi);
        check("boundary_cycles", 32'(hi), 32'(TO));
        check_reg("status_done_wins", 4'd10, 8'h02);
        check_reg("res_boundary_b3", 4'd15, 8'hDE);

        // Writes while busy are rejected and flagged
        core_lat = 20; core_val = 32'h1234_5678;
        wr_reg(4'd9, 8'h02);
        wr_reg(4'd9, 8'h01);
        wr_reg(4'd0, 8'h55);
        check("busy_a_held", a_operand, 32'h3F80_0000);
        check_reg("status_busy_err", 4'd10, 8'h05);
        check_reg("stale_result", 4'd12, 8'hEF);
        wr_reg(4'd8, 8'h03);
        check("busy_op_held", 32'(operation), 32'd0);
        run_op(hi);
        check_reg("status_done_err", 4'd10, 8'h06);
        check_reg("new_result_b0", 4'd12, 8'h78);

        // Held write strobe gives one start; IRQ follows done
        wr_reg(4'd9, 8'h02);
        wr_reg(4'd8, 8'h80);
        check_reg("reg8_readback", 4'd8, 8'h80);
        r0 = start_rises;
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 4'd9; din = 8'h01;
        repeat (5) @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        run_op(hi);
        repeat (5) @(negedge clk);
        check("held_one_start", 32'(start_rises - r0), 32'd1);
        check_reg("status_held", 4'd10, 8'h02);
        check("irq_set", 32'(irq), 32'd1);
        wr_reg(4'd9, 8'h02);
        check("irq_cleared", 32'(irq), 32'd0);

        // Asynchronous reset in the middle of an operation
        wr_reg(4'd9, 8'h01);
        repeat (5) @(negedge clk);
        arst = 1'b1;
        #1;
        check("arst_core_start", 32'(core_start), 32'd0);
        check("arst_a", a_operand, 32'd0);
        check("arst_op", 32'(operation), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        check_reg("arst_status", 4'd10, 8'h00);
        check_reg("arst_reg8", 4'd8, 8'h00);
        check_reg("arst_result", 4'd12, 8'h00);
        core_val = 32'h4040_0000;
        load_ops(32'h3F80_0000, 32'h4000_0000, 8'h00);
        wr_reg(4'd9, 8'h01);
        run_op(hi);
        check("post_rst_cycles", 32'(hi), 32'd20);
        check_reg("post_rst_status", 4'd10, 8'h02);
        check_reg("post_rst_res_b2", 4'd14, 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
